// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC control sequencer: sizing constants, FSM state
// encoding and the kernel-size legality check.
package mac_sequencer_pkg;

    localparam int MAX_KERNEL  = 5;
    localparam int KERNEL_TAPS = MAX_KERNEL * MAX_KERNEL;
    localparam int KSIZE_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    function automatic logic kernel_legal(input logic [KSIZE_W-1:0] k);
        return (k != '0) && (int'(k) <= MAX_KERNEL);
    endfunction

endpackage

// File: rtl/mac_sequencer_valid_pipe.sv
// Fixed-latency shift register that carries the valid tag and column index of
// each FIFO read so they line up with the matching MAC_out.
module mac_sequencer_valid_pipe #(
    parameter int DEPTH = 2,
    parameter int COL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_tag,
    input  logic [COL_W-1:0] in_col,
    output logic             out_tag,
    output logic [COL_W-1:0] out_col
);

    typedef struct packed {
        logic             tag;
        logic [COL_W-1:0] col;
    } slot_t;

    slot_t stage [DEPTH];

    // NOTE: these stages are reset, unlike a plain data store, because a stale tag would surface as a phantom result after a mid-job reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= '{tag: in_tag, col: in_col};
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_tag = stage[DEPTH-1].tag;
    assign out_col = stage[DEPTH-1].col;

endmodule

// File: rtl/mac_sequencer.sv
// Control sequencer for one MAC unit: loads the kernel, streams ifmap columns
// into the MAC FIFO, issues FIFO reads and tags valid window results.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int COL_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ALU_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [KSIZE_W-1:0]     cfg_kernel_size,
    input  logic                   cfg_operation,
    input  logic [COL_W-1:0]       cfg_width,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic                   w_valid,
    input  logic [KERNEL_TAPS-1:0] w_data,
    output logic                   w_ready,
    input  logic                   src_valid,
    output logic                   src_ready,
    output logic [KERNEL_TAPS-1:0] weight_out,
    output logic                   load_weight,
    output logic                   ifmaps_input_valid,
    output logic                   load_ifmaps,
    output logic [KSIZE_W-1:0]     kernel_size,
    output logic                   operation,
    output logic                   out_valid,
    output logic [COL_W-1:0]       out_col
);

    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
    localparam int DRN_W  = $clog2(ALU_LAT) + 1;

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FIFO_DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(ALU_LAT - 1);
    localparam logic [DRN_W-1:0]  DRN_ONE  = DRN_W'(1);

    state_e             state, state_nx;
    logic [COL_W-1:0]   width_q, wr_cnt, rd_cnt, k_col, rd_col;
    logic [FILL_W-1:0]  fill;
    logic [DRN_W-1:0]   drain_cnt;
    logic               cfg_ok, idle_start, rd_tag;

    assign idle_start = (state == ST_IDLE) && cfg_start;
    assign cfg_ok     = kernel_legal(cfg_kernel_size)
                     && (int'(cfg_width) >= int'(cfg_kernel_size));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_nx    = state;
        w_ready     = 1'b0;
        src_ready   = 1'b0;
        load_ifmaps = 1'b0;
        done        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cfg_start && cfg_ok) state_nx = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                src_ready   = (wr_cnt < width_q) && (fill < FILL_MAX);
                // Reads see the fill level at cycle start; a same-cycle write is not yet readable.
                load_ifmaps = (rd_cnt < width_q) && (fill != '0);
                if (load_ifmaps && (rd_cnt == width_q - COL_ONE)) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == DRN_LAST) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy               = (state != ST_IDLE);
    assign ifmaps_input_valid = src_valid && src_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_size <= '0;
            operation   <= 1'b0;
            width_q     <= '0;
            err         <= 1'b0;
            weight_out  <= '0;
            load_weight <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            fill        <= '0;
            drain_cnt   <= '0;
        end else begin
            err         <= idle_start && !cfg_ok;
            load_weight <= 1'b0;
            if (idle_start) begin
                kernel_size <= cfg_kernel_size;
                operation   <= cfg_operation;
                width_q     <= cfg_width;
                wr_cnt      <= '0;
                rd_cnt      <= '0;
                fill        <= '0;
                drain_cnt   <= '0;
            end
            if ((state == ST_LOAD_W) && w_valid) begin
                weight_out  <= w_data;
                load_weight <= 1'b1;
            end
            if (ifmaps_input_valid) wr_cnt <= wr_cnt + COL_ONE;
            if (load_ifmaps)        rd_cnt <= rd_cnt + COL_ONE;
            unique case ({ifmaps_input_valid, load_ifmaps})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase
            if (state == ST_DRAIN) drain_cnt <= drain_cnt + DRN_ONE;
        end
    end

    // A read produces a valid window once K columns have entered the ALU.
    assign k_col  = COL_W'(kernel_size);
    assign rd_tag = load_ifmaps && (rd_cnt >= k_col - COL_ONE);
    assign rd_col = rd_tag ? (rd_cnt - k_col + COL_ONE) : '0;

    mac_sequencer_valid_pipe #(
        .DEPTH (ALU_LAT),
        .COL_W (COL_W)
    ) u_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_tag  (rd_tag),
        .in_col  (rd_col),
        .out_tag (out_valid),
        .out_col (out_col)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fill <= FILL_MAX);
            assert (!(load_ifmaps && (fill == '0)));
        end
    end

endmodule
